// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor
//   Independent safety monitor for the main/side signal-head buses of an
//   intersection controller. Both 3-bit light codes are sampled every clock.
//   The monitor flags these conditions: invalid codes, green/yellow conflicts,
//   illegal colour steps, short yellows and short all-red clearance. The first
//   fault cause is latched and drives a red-flash enable until a clear is
//   requested while both heads show red.
//
// Parameters
//   FILTER_CYC : consecutive clocks an invalid/conflict condition must persist
//   MIN_YELLOW : minimum yellow duration in ticks
//   MIN_CLEAR  : minimum all-red duration (ticks) before a green
//   CNT_W      : width of the saturating tick/filter counters
//
// Ports
//   clk         : system clock
//   reset       : asynchronous, active-high reset
//   tick        : one-clock timebase pulse
//   main_lights : main head code (100 red, 010 yellow, 001 green)
//   side_lights : side head code, same encoding
//   fault_clr   : fault clear request (honoured in FAULT with both heads red)
//   fault       : latched fault flag
//   fault_code  : first fault cause (0 none, 1 invalid, 2 conflict,
//                 3 illegal transition, 4 short yellow, 5 short clearance)
//   flash       : red-flash drive, toggles per tick while faulted
//   ok          : high only while monitoring
module traffic_conflict_monitor #(
  parameter int unsigned FILTER_CYC = 2,
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned MIN_CLEAR  = 1,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [2:0] main_lights,
  input  logic [2:0] side_lights,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash,
  output logic       ok
);

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_INVALID = 3'd1;
  localparam logic [2:0] FC_CONFL   = 3'd2;
  localparam logic [2:0] FC_TRANS   = 3'd3;
  localparam logic [2:0] FC_SHORT_Y = 3'd4;
  localparam logic [2:0] FC_SHORT_C = 3'd5;

  localparam logic [CNT_W-1:0] FILT_LIM  = CNT_W'(FILTER_CYC);
  localparam logic [CNT_W-1:0] YEL_LIM   = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] CLEAR_LIM = CNT_W'(MIN_CLEAR);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic             flash_q, flash_d;
  logic             ok_q, ok_d;
  logic [CNT_W-1:0] inv_cnt_q, inv_cnt_d;
  logic [CNT_W-1:0] cnf_cnt_q, cnf_cnt_d;
  logic [CNT_W-1:0] ym_cnt_q, ym_cnt_d;
  logic [CNT_W-1:0] ys_cnt_q, ys_cnt_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [2:0]       prev_main_q, prev_main_d;
  logic [2:0]       prev_side_q, prev_side_d;
  logic             first_grn_q, first_grn_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic is_valid(input logic [2:0] c);
    return (c == LT_RED) || (c == LT_YEL) || (c == LT_GRN);
  endfunction

  // Only G->R, R->Y and Y->G are forbidden; unchanged, R->G, G->Y, Y->R pass.
  function automatic logic is_illegal(input logic [2:0] p, input logic [2:0] c);
    return ((p == LT_GRN) && (c == LT_RED)) ||
           ((p == LT_RED) && (c == LT_YEL)) ||
           ((p == LT_YEL) && (c == LT_GRN));
  endfunction

  // Sampled-condition decode
  logic             main_ok, side_ok;
  logic             any_invalid, conflict;
  logic             both_red, prev_both_red;
  logic             m_r2g, s_r2g, m_y2r, s_y2r;
  logic             illegal_step;
  logic [CNT_W-1:0] inv_inc, cnf_inc;
  logic             inv_hit, cnf_hit;
  logic             short_yel, short_clr;

  assign main_ok       = is_valid(main_lights);
  assign side_ok       = is_valid(side_lights);
  assign any_invalid   = !main_ok || !side_ok;
  assign conflict      = main_ok && side_ok &&
                         (main_lights != LT_RED) && (side_lights != LT_RED);
  assign both_red      = (main_lights == LT_RED) && (side_lights == LT_RED);
  assign prev_both_red = (prev_main_q == LT_RED) && (prev_side_q == LT_RED);

  assign m_r2g = (prev_main_q == LT_RED) && (main_lights == LT_GRN);
  assign s_r2g = (prev_side_q == LT_RED) && (side_lights == LT_GRN);
  assign m_y2r = (prev_main_q == LT_YEL) && (main_lights == LT_RED);
  assign s_y2r = (prev_side_q == LT_YEL) && (side_lights == LT_RED);

  // Invalid codes never match a legal pattern, so no extra valid qualifier.
  assign illegal_step = is_illegal(prev_main_q, main_lights) ||
                        is_illegal(prev_side_q, side_lights);

  assign inv_inc = sat_inc(inv_cnt_q);
  assign cnf_inc = sat_inc(cnf_cnt_q);
  assign inv_hit = any_invalid && (inv_inc >= FILT_LIM);
  assign cnf_hit = conflict && (cnf_inc >= FILT_LIM);

  // Registered counts are used, so a tick on the Y->R edge itself is excluded.
  assign short_yel = (m_y2r && (ym_cnt_q < YEL_LIM)) ||
                     (s_y2r && (ys_cnt_q < YEL_LIM));
  assign short_clr = (m_r2g || s_r2g) && !first_grn_q && (clr_cnt_q < CLEAR_LIM);

  // Counter/prev values while tracking (INIT and MONITOR)
  logic [CNT_W-1:0] inv_trk, cnf_trk, ym_trk, ys_trk, clr_trk;
  logic [2:0]       pm_trk, ps_trk;

  always_comb begin
    inv_trk = any_invalid ? inv_inc : '0;
    cnf_trk = conflict ? cnf_inc : '0;

    // Entry into yellow clears the count; a tick on that same edge is ignored.
    ym_trk = ym_cnt_q;
    if ((main_lights == LT_YEL) && (prev_main_q != LT_YEL)) begin
      ym_trk = '0;
    end else if ((main_lights == LT_YEL) && tick) begin
      ym_trk = sat_inc(ym_cnt_q);
    end

    ys_trk = ys_cnt_q;
    if ((side_lights == LT_YEL) && (prev_side_q != LT_YEL)) begin
      ys_trk = '0;
    end else if ((side_lights == LT_YEL) && tick) begin
      ys_trk = sat_inc(ys_cnt_q);
    end

    clr_trk = clr_cnt_q;
    if (both_red && !prev_both_red) begin
      clr_trk = '0;
    end else if (both_red && tick) begin
      clr_trk = sat_inc(clr_cnt_q);
    end

    pm_trk = main_ok ? main_lights : prev_main_q;
    ps_trk = side_ok ? side_lights : prev_side_q;
  end

  // Next-state / output logic
  logic [2:0] cause;

  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    code_d      = code_q;
    flash_d     = flash_q;
    inv_cnt_d   = inv_cnt_q;
    cnf_cnt_d   = cnf_cnt_q;
    ym_cnt_d    = ym_cnt_q;
    ys_cnt_d    = ys_cnt_q;
    clr_cnt_d   = clr_cnt_q;
    prev_main_d = prev_main_q;
    prev_side_d = prev_side_q;
    first_grn_d = first_grn_q;
    cause       = FC_NONE;

    case (state_q)
      ST_INIT: begin
        inv_cnt_d   = inv_trk;
        cnf_cnt_d   = cnf_trk;
        ym_cnt_d    = ym_trk;
        ys_cnt_d    = ys_trk;
        clr_cnt_d   = clr_trk;
        prev_main_d = pm_trk;
        prev_side_d = ps_trk;
        if (inv_hit) begin
          cause = FC_INVALID;
        end else if (cnf_hit) begin
          cause = FC_CONFL;
        end else if (both_red) begin
          state_d     = ST_MONITOR;
          first_grn_d = 1'b1;
        end
      end

      ST_MONITOR: begin
        inv_cnt_d   = inv_trk;
        cnf_cnt_d   = cnf_trk;
        ym_cnt_d    = ym_trk;
        ys_cnt_d    = ys_trk;
        clr_cnt_d   = clr_trk;
        prev_main_d = pm_trk;
        prev_side_d = ps_trk;
        if (m_r2g || s_r2g) begin
          first_grn_d = 1'b0;
        end
        // Lowest code number wins when several causes coincide.
        if (inv_hit) begin
          cause = FC_INVALID;
        end else if (cnf_hit) begin
          cause = FC_CONFL;
        end else if (illegal_step) begin
          cause = FC_TRANS;
        end else if (short_yel) begin
          cause = FC_SHORT_Y;
        end else if (short_clr) begin
          cause = FC_SHORT_C;
        end
      end

      ST_FAULT: begin
        if (fault_clr && both_red) begin
          state_d     = ST_INIT;
          fault_d     = 1'b0;
          code_d      = FC_NONE;
          flash_d     = 1'b0;
          inv_cnt_d   = '0;
          cnf_cnt_d   = '0;
          ym_cnt_d    = '0;
          ys_cnt_d    = '0;
          clr_cnt_d   = '0;
          prev_main_d = LT_RED;
          prev_side_d = LT_RED;
        end else if (tick) begin
          flash_d = ~flash_q;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (cause != FC_NONE) begin
      state_d = ST_FAULT;
      fault_d = 1'b1;
      code_d  = cause;
      flash_d = 1'b1;
    end

    ok_d = (state_d == ST_MONITOR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      fault_q     <= 1'b0;
      code_q      <= FC_NONE;
      flash_q     <= 1'b0;
      ok_q        <= 1'b0;
      inv_cnt_q   <= '0;
      cnf_cnt_q   <= '0;
      ym_cnt_q    <= '0;
      ys_cnt_q    <= '0;
      clr_cnt_q   <= '0;
      prev_main_q <= LT_RED;
      prev_side_q <= LT_RED;
      first_grn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      flash_q     <= flash_d;
      ok_q        <= ok_d;
      inv_cnt_q   <= inv_cnt_d;
      cnf_cnt_q   <= cnf_cnt_d;
      ym_cnt_q    <= ym_cnt_d;
      ys_cnt_q    <= ys_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      prev_main_q <= prev_main_d;
      prev_side_q <= prev_side_d;
      first_grn_q <= first_grn_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign flash      = flash_q;
  assign ok         = ok_q;

endmodule
